if_id_stage: RTL and testbench
==============================

IF_ID_STAGE -- requirements
Module: if_id_stage

Interface
REQ-001 SHALL have one clock and an asynchronous, active-high reset: clk and rst.
REQ-002 SHALL have parameter RESET_PC, default 32'h0000_0000, the first fetch address after reset.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  asynchronous active-high reset.
REQ-005 stall  input  1  hazard request; holds the PC and the IF/ID register.
REQ-006 flush  input  1  invalidates IF/ID content; takes priority over stall.
REQ-007 branch_taken  input  1  one-cycle redirect request.
REQ-008 branch_target  input  32  redirect address, sampled with branch_taken.
REQ-009 imem_req  output  1  fetch request to instruction memory.
REQ-010 imem_addr  output  32  fetch address; equals the PC.
REQ-011 imem_ack  input  1  imem_rdata valid this cycle; legal in the same cycle as imem_req rises.
REQ-012 imem_rdata  input  32  fetched instruction word.
REQ-013 if_id_instr  output  32  registered instruction for decode.
REQ-014 if_id_pc4  output  32  registered PC+4 of that instruction.
REQ-015 if_id_valid  output  1  if_id_instr is a real instruction, not a bubble.
REQ-016 opcode  output  6  if_id_instr[31:26], feeds the main control unit.
REQ-017 funct  output  6  if_id_instr[5:0], feeds ALU control.

Function
REQ-018 FSM states: IDLE, FETCH, HOLD.
REQ-019 IDLE lasts exactly one cycle after reset release and then goes to FETCH.
REQ-020 imem_req SHALL be 1 in FETCH only.
REQ-021 imem_addr SHALL be stable while imem_req=1 and imem_ack=0.
REQ-022 FETCH, ack=1, stall=0, no redirect pending, branch_taken=0:
  - IF/ID loads {imem_rdata, PC+4, valid=1}.
  - PC <= PC+4.
  - state stays FETCH.
  - Throughput is one instruction per cycle with zero-wait memory.
REQ-023 FETCH, ack=0, stall=0: if_id_valid <= 0 (bubble); PC holds.
REQ-024 branch_taken with ack=1 in the same cycle: the fetched word is discarded (if_id_valid <= 0) and PC <= branch_target.
REQ-025 branch_taken with ack=0: branch_target is saved and redirect_pending is set.
  - On the next ack, the response is discarded as a bubble.
  - PC <= saved target and redirect_pending clears.
  - A later branch_taken overwrites the saved target.
REQ-026 FETCH, ack=1, stall=1:
  - The response is captured into a skid register and the state goes to HOLD.
  - IF/ID and PC+4 update are deferred.
REQ-027 FETCH, ack=0, stall=1: IF/ID holds all fields, including valid.
REQ-028 HOLD:
  - No request is issued.
  - When stall drops, IF/ID loads the skid word (valid=1), PC <= PC+4 and the state goes to FETCH.
REQ-029 flush=1 forces if_id_valid <= 0 in the same clock regardless of stall.
  - In HOLD, flush discards the skid word and returns to FETCH.
  - PC SHALL NOT advance on that discard.
REQ-030 flush together with branch_taken SHALL apply both: bubble, and the redirect per REQ-024/025.
REQ-031 PC+4 arithmetic is 32-bit modulo: 32'hFFFF_FFFC wraps to 32'h0000_0000.
REQ-032 opcode and funct SHALL be combinational slices of if_id_instr with no added latency.

Reset
REQ-033 While rst=1, and immediately on its assertion, the block SHALL drive:
  - PC=RESET_PC and state=IDLE.
  - imem_req=0.
  - if_id_instr=0, if_id_pc4=0, if_id_valid=0.
  - skid register=0, redirect_pending=0.
REQ-034 rst asserted mid-fetch abandons the outstanding request; an ack arriving during reset is ignored.

Structure
REQ-035 Shared package if_pkg SHALL hold:
  - the FSM state enum.
  - the RESET_PC default.
  - opcode constants OP_RTYPE=6'b000000, OP_LW=6'b100011, OP_SW=6'b101011.
REQ-036 The pipeline register SHALL be sub-module if_id_reg (load/hold/clear-valid controls). PC, FSM and skid logic stay in if_id_stage.

Verification
REQ-037 Reset, then zero-wait memory returning 32'h8C080004, 32'hAC090008, 32'h01095020:
  - The first ack appears 2 cycles after reset release.
  - if_id_instr shows those words on consecutive cycles, with pc4 = 4, 8, 12 and valid=1.
  - opcode reads 100011, 101011, 000000.
REQ-038 Ack delayed 3 cycles at PC=0x10:
  - imem_addr holds 0x10 throughout.
  - Three bubbles (valid=0) are produced, then the instruction appears with pc4=0x14.
REQ-039 stall=1 for 2 cycles during a zero-wait ack at PC=0x20:
  - The state enters HOLD and IF/ID is unchanged.
  - When stall drops, the 0x20 word appears with pc4=0x24, and the next imem_addr is 0x24.
REQ-040 branch_taken with target 0x100 while the ack at PC=0x40 is pending:
  - The 0x40 response is dropped.
  - The next imem_addr is 0x100 and no instruction from 0x44 ever becomes valid.
REQ-041 flush during HOLD: valid=0 the next cycle, the skid word is never delivered, and fetch resumes at the held PC.
REQ-042 rst asserted during WAIT with a late ack: outputs are at reset values asynchronously, and the ack is ignored.

Source files
------------

// File: rtl/if_pkg.sv
// Shared types and constants for the instruction-fetch / IF-ID pipeline slice.
package if_pkg;

    // Fetch sequencer states.
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_HOLD  = 2'd2
    } if_state_e;

    // Default first fetch address after reset.
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    // Primary opcodes decoded downstream from if_id_instr[31:26].
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    // Sequential PC increment; 32-bit modulo so 0xFFFF_FFFC wraps to 0.
    function automatic logic [31:0] pc_next(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: load a new instruction, hold, or clear valid.
// clear wins over load; data fields are kept on clear so only valid drops.
module if_id_reg (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        clear,
    input  logic [31:0] instr_in,
    input  logic [31:0] pc4_in,
    output logic [31:0] instr,
    output logic [31:0] pc4,
    output logic        valid
);

    logic [31:0] instr_q, instr_d;
    logic [31:0] pc4_q, pc4_d;
    logic        valid_q, valid_d;

    // Next-state selection: clear-valid, load, or hold.
    always_comb begin
        instr_d = instr_q;
        pc4_d   = pc4_q;
        valid_d = valid_q;
        if (clear) begin
            valid_d = 1'b0;
        end else if (load) begin
            instr_d = instr_in;
            pc4_d   = pc4_in;
            valid_d = 1'b1;
        end else begin
            valid_d = valid_q;
        end
    end

    // Pipeline register storage with asynchronous reset to an empty bubble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instr_q <= 32'h0000_0000;
            pc4_q   <= 32'h0000_0000;
            valid_q <= 1'b0;
        end else begin
            instr_q <= instr_d;
            pc4_q   <= pc4_d;
            valid_q <= valid_d;
        end
    end

    assign instr = instr_q;
    assign pc4   = pc4_q;
    assign valid = valid_q;

endmodule

// File: rtl/if_id_stage.sv
// Instruction fetch stage: PC, fetch sequencer, skid buffer for responses
// that arrive while decode is stalled, branch redirect tracking, and the
// IF/ID pipeline register feeding decode.
module if_id_stage #(
    parameter logic [31:0] RESET_PC = if_pkg::RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        flush,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc4,
    output logic        if_id_valid,
    output logic [5:0]  opcode,
    output logic [5:0]  funct
);

    import if_pkg::*;

    if_state_e   state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] skid_q, skid_d;
    logic        redir_q, redir_d;
    logic [31:0] tgt_q, tgt_d;
    logic        req_q;

    logic        reg_load;
    logic        reg_clear;
    logic        bubble_ok;
    logic [31:0] pc_plus4;
    logic [31:0] reg_instr_in;

    // A discarded/missing response becomes a bubble unless a stall (without
    // flush) asks the IF/ID register to keep what it already holds.
    assign bubble_ok    = flush | ~stall;
    assign pc_plus4     = pc_next(pc_q);
    assign reg_instr_in = (state_q == S_HOLD) ? skid_q : imem_rdata;

    // Fetch sequencer: next PC, state, skid, redirect and IF/ID controls.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        skid_d    = skid_q;
        redir_d   = redir_q;
        tgt_d     = tgt_q;
        reg_load  = 1'b0;
        reg_clear = 1'b0;
        case (state_q)
            S_IDLE: begin
                state_d = S_FETCH;
            end
            S_FETCH: begin
                if (branch_taken) begin
                    reg_clear = bubble_ok;
                    if (imem_ack) begin
                        pc_d    = branch_target;
                        redir_d = 1'b0;
                    end else begin
                        tgt_d   = branch_target;
                        redir_d = 1'b1;
                    end
                end else if (redir_q) begin
                    // Response for the abandoned address is dropped.
                    reg_clear = bubble_ok;
                    if (imem_ack) begin
                        pc_d    = tgt_q;
                        redir_d = 1'b0;
                    end else begin
                        pc_d    = pc_q;
                    end
                end else if (imem_ack) begin
                    if (flush) begin
                        // Squashed response; PC holds so the word is refetched.
                        reg_clear = 1'b1;
                    end else if (stall) begin
                        skid_d  = imem_rdata;
                        state_d = S_HOLD;
                    end else begin
                        reg_load = 1'b1;
                        pc_d     = pc_plus4;
                    end
                end else begin
                    reg_clear = bubble_ok;
                end
            end
            S_HOLD: begin
                if (branch_taken) begin
                    pc_d      = branch_target;
                    skid_d    = 32'h0000_0000;
                    state_d   = S_FETCH;
                    reg_clear = bubble_ok;
                end else if (flush) begin
                    reg_clear = 1'b1;
                    skid_d    = 32'h0000_0000;
                    state_d   = S_FETCH;
                end else if (!stall) begin
                    reg_load = 1'b1;
                    pc_d     = pc_plus4;
                    skid_d   = 32'h0000_0000;
                    state_d  = S_FETCH;
                end else begin
                    state_d  = S_HOLD;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Sequencer state, PC, skid and redirect registers; request is registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_PC;
            skid_q  <= 32'h0000_0000;
            redir_q <= 1'b0;
            tgt_q   <= 32'h0000_0000;
            req_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            skid_q  <= skid_d;
            redir_q <= redir_d;
            tgt_q   <= tgt_d;
            req_q   <= (state_d == S_FETCH);
        end
    end

    assign imem_req  = req_q;
    assign imem_addr = pc_q;

    if_id_reg u_if_id_reg (
        .clk      (clk),
        .rst      (rst),
        .load     (reg_load),
        .clear    (reg_clear),
        .instr_in (reg_instr_in),
        .pc4_in   (pc_plus4),
        .instr    (if_id_instr),
        .pc4      (if_id_pc4),
        .valid    (if_id_valid)
    );

    assign opcode = if_id_instr[31:26];
    assign funct  = if_id_instr[5:0];

endmodule

// File: tb/tb_if_id_stage.sv
// Scoreboard bench for if_id_stage: directed fetch sequences push expected
// decode words; a monitor pops and compares each newly loaded IF/ID entry.
module tb_if_id_stage;

    import if_pkg::*;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        flush;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc4;
    logic        if_id_valid;
    logic [5:0]  opcode;
    logic [5:0]  funct;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc4;
        logic [5:0]  op;
    } exp_t;

    exp_t        sb[$];
    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] corrupt = 32'h0000_0000;

    if_id_stage #(.RESET_PC(32'h0000_0000)) dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .flush         (flush),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .imem_rdata    (imem_rdata),
        .if_id_instr   (if_id_instr),
        .if_id_pc4     (if_id_pc4),
        .if_id_valid   (if_id_valid),
        .opcode        (opcode),
        .funct         (funct)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0000_0000: return 32'h8C08_0004;
            32'h0000_0004: return 32'hAC09_0008;
            32'h0000_0008: return 32'h0109_5020;
            default:       return {6'b000100, a[25:0]};
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %h, required %h", name, act, expv);
        end
    endtask

    task automatic push(input logic [31:0] i, input logic [31:0] p, input logic [5:0] o);
        exp_t e;
        e.instr = i;
        e.pc4   = p;
        e.op    = o;
        sb.push_back(e);
    endtask

    // One cycle: drive inputs at negedge, memory answers the current request.
    task automatic step(input logic a, input logic s, input logic f,
                        input logic b, input logic [31:0] t);
        @(negedge clk);
        stall         = s;
        flush         = f;
        branch_taken  = b;
        branch_target = t;
        imem_ack      = a & imem_req;
        imem_rdata    = (a & imem_req) ? (mem_word(imem_addr) ^ corrupt) : 32'hDEAD_BEEF;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_req"},   {31'd0, imem_req},    32'd0);
        chk({tag, "_addr"},  imem_addr,            32'h0000_0000);
        chk({tag, "_instr"}, if_id_instr,          32'h0000_0000);
        chk({tag, "_pc4"},   if_id_pc4,            32'h0000_0000);
        chk({tag, "_valid"}, {31'd0, if_id_valid}, 32'd0);
    endtask

    // Monitor: compare every IF/ID load (valid and not held by stall).
    always @(posedge clk) begin : mon
        logic stall_edge;
        exp_t e;
        stall_edge = stall;
        #1;
        if (!rst && if_id_valid && !stall_edge) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_valid: got instr %h pc4 %h, required no output",
                         if_id_instr, if_id_pc4);
            end else begin
                e = sb.pop_front();
                chk("sb_instr",  if_id_instr,       e.instr);
                chk("sb_pc4",    if_id_pc4,         e.pc4);
                chk("sb_opcode", {26'd0, opcode},   {26'd0, e.op});
                chk("sb_funct",  {26'd0, funct},    {26'd0, e.instr[5:0]});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish, required finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; stall = 1'b0; flush = 1'b0; branch_taken = 1'b0;
        branch_target = 32'h0000_0000; imem_ack = 1'b0; imem_rdata = 32'h0000_0000;
        repeat (3) @(posedge clk);
        #1;
        chk_reset("rst");

        // Release reset; one IDLE cycle with no request, then fetch at 0.
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("idle_req", {31'd0, imem_req}, 32'd0);
        @(posedge clk);
        #1;
        chk("fetch_req",  {31'd0, imem_req}, 32'd1);
        chk("fetch_addr", imem_addr, 32'h0000_0000);

        // Zero-wait sequence of three words.
        push(32'h8C08_0004, 32'h0000_0004, 6'b100011); step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        push(32'hAC09_0008, 32'h0000_0008, 6'b101011); step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        push(32'h0109_5020, 32'h0000_000C, 6'b000000); step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        push(32'h1000_000C, 32'h0000_0010, 6'b000100); step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);

        // Ack delayed three cycles at 0x10: address stable, three bubbles.
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
            chk("wait_addr",  imem_addr, 32'h0000_0010);
            chk("wait_valid", {31'd0, if_id_valid}, 32'd0);
        end
        push(32'h1000_0010, 32'h0000_0014, 6'b000100); step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        for (int a = 32'h14; a < 32'h20; a += 4) begin
            push(mem_word(a), a + 4, 6'b000100);
            step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        end

        // Stall during the ack at 0x20: response goes to skid, IF/ID held.
        step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        chk("hold_state", {30'd0, dut.state_q}, {30'd0, S_HOLD});
        chk("hold_req",   {31'd0, imem_req},    32'd0);
        chk("hold_instr", if_id_instr,          32'h1000_001C);
        chk("hold_pc4",   if_id_pc4,            32'h0000_0020);
        step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        chk("hold2_pc4",  if_id_pc4,            32'h0000_0020);
        push(32'h1000_0020, 32'h0000_0024, 6'b000100); step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        chk("unhold_addr", imem_addr, 32'h0000_0024);
        chk("unhold_req",  {31'd0, imem_req}, 32'd1);
        for (int a = 32'h24; a < 32'h40; a += 4) begin
            push(mem_word(a), a + 4, 6'b000100);
            step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        end

        // Branch while 0x40 is pending; second branch overwrites the target.
        step(1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0180);
        chk("br_addr", imem_addr, 32'h0000_0040);
        step(1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0100);
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        chk("br_drop_valid", {31'd0, if_id_valid}, 32'd0);
        chk("br_new_addr",   imem_addr, 32'h0000_0100);
        push(32'h1000_0100, 32'h0000_0104, 6'b000100); step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);

        // Flush during HOLD: skid word (marked) is dropped, refetch at 0x104.
        corrupt = 32'h00FF_0000;
        step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        corrupt = 32'h0000_0000;
        chk("fl_state", {30'd0, dut.state_q}, {30'd0, S_HOLD});
        step(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
        chk("fl_valid", {31'd0, if_id_valid}, 32'd0);
        chk("fl_addr",  imem_addr, 32'h0000_0104);
        chk("fl_req",   {31'd0, imem_req}, 32'd1);
        push(32'h1000_0104, 32'h0000_0108, 6'b000100); step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);

        // Reset while waiting at 0x108, with an ack arriving during reset.
        step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        #2;
        rst = 1'b1;
        #1;
        chk_reset("arst");
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            imem_ack   = 1'b1;
            imem_rdata = 32'h1234_5678;
            @(posedge clk);
            #1;
        end
        chk_reset("rst_ack");
        @(negedge clk);
        rst = 1'b0;
        imem_ack = 1'b0;
        @(posedge clk);
        #1;
        chk("re_addr", imem_addr, 32'h0000_0000);
        push(32'h8C08_0004, 32'h0000_0004, 6'b100011); step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);

        // PC+4 wrap at the top of the address space.
        step(1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        chk("wrap_addr", imem_addr, 32'hFFFF_FFFC);
        push(32'h13FF_FFFC, 32'h0000_0000, 6'b000100); step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        chk("wrap_next", imem_addr, 32'h0000_0000);
        step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);

        chk("sb_empty", sb.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
